// File: rtl/scr1_div_trace_buf.sv
// Trace FIFO for DIV/DIVU/REM/REMU seen on the imem response path.
// Optional divide-by-zero tracking: define SCR1_DIV_TRACE_DIVZERO_EN.
module scr1_div_trace_buf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       imem_resp,
  input  logic [31:0]      imem_rdata,
  output logic [4:0]       mprf_rs1_addr,
  output logic [4:0]       mprf_rs2_addr,
  input  logic [31:0]      mprf_rs1_data,
  input  logic [31:0]      mprf_rs2_data,
  output logic             trc_vld,
  input  logic             trc_rdy,
  output logic [1:0]       trc_op,
  output logic [31:0]      trc_dividend,
  output logic [31:0]      trc_divisor,
  output logic             trc_dz,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [7:0]       drop_cnt,
  output logic             ovf,
  output logic             dz_seen
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [7:0]       drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic [1:0]  op_mem  [DEPTH];
  logic [31:0] dvd_mem [DEPTH];
  logic [31:0] dvs_mem [DEPTH];

  logic        detect;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        unused_rd;

  assign mprf_rs1_addr = imem_rdata[19:15];
  assign mprf_rs2_addr = imem_rdata[24:20];
  assign unused_rd     = ^imem_rdata[11:7];

  assign detect = (imem_resp == 2'b01)
                & (imem_rdata[6:0] == 7'b0110011)
                & (imem_rdata[31:25] == 7'b0000001)
                & imem_rdata[14];

  // x0 always reads as zero, whatever the register file returns
  assign rs1_val = (mprf_rs1_addr == 5'd0) ? 32'h0 : mprf_rs1_data;
  assign rs2_val = (mprf_rs2_addr == 5'd0) ? 32'h0 : mprf_rs2_data;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW])
               & (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign trc_vld = ~empty;
  assign pop     = trc_vld & trc_rdy;
  // a pop frees the slot in the same cycle, so full+pop still accepts
  assign push    = detect & (~full | pop);
  assign drop    = detect & full & ~pop;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    evt_d  = evt_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      evt_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (pop)
        rd_d = rd_q + (AW+1)'(1);
      if (push)
        wr_d = wr_q + (AW+1)'(1);
      if (detect && (evt_q != '1))
        evt_d = evt_q + CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF)
          drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      evt_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      evt_q  <= evt_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push) begin
      op_mem[wr_q[AW-1:0]]  <= imem_rdata[13:12];
      dvd_mem[wr_q[AW-1:0]] <= rs1_val;
      dvs_mem[wr_q[AW-1:0]] <= rs2_val;
    end
  end

  assign trc_op       = op_mem[rd_q[AW-1:0]];
  assign trc_dividend = dvd_mem[rd_q[AW-1:0]];
  assign trc_divisor  = dvs_mem[rd_q[AW-1:0]];
  assign evt_cnt      = evt_q;
  assign drop_cnt     = drop_q;
  assign ovf          = ovf_q;

`ifdef SCR1_DIV_TRACE_DIVZERO_EN
  logic dz_mem [DEPTH];
  logic dz_seen_q;
  logic dz_flag;

  assign dz_flag = (rs2_val == 32'h0);

  always_ff @(posedge clk) begin
    if (!clr && push)
      dz_mem[wr_q[AW-1:0]] <= dz_flag;
  end

  // dropped events still mark the sticky flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dz_seen_q <= 1'b0;
    else if (clr)
      dz_seen_q <= 1'b0;
    else if (detect && dz_flag)
      dz_seen_q <= 1'b1;
  end

  assign trc_dz  = trc_vld & dz_mem[rd_q[AW-1:0]];
  assign dz_seen = dz_seen_q;
`else
  assign trc_dz  = 1'b0;
  assign dz_seen = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_div_trace_buf.sv
// Directed bench for scr1_div_trace_buf.
// Expectations follow SCR1_DIV_TRACE_DIVZERO_EN when defined.
module tb_scr1_div_trace_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [1:0]  imem_resp;
  logic [31:0] imem_rdata;
  logic [4:0]  mprf_rs1_addr;
  logic [4:0]  mprf_rs2_addr;
  logic [31:0] mprf_rs1_data;
  logic [31:0] mprf_rs2_data;
  logic        trc_vld;
  logic        trc_rdy;
  logic [1:0]  trc_op;
  logic [31:0] trc_dividend;
  logic [31:0] trc_divisor;
  logic        trc_dz;
  logic [15:0] evt_cnt;
  logic [7:0]  drop_cnt;
  logic        ovf;
  logic        dz_seen;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SCR1_DIV_TRACE_DIVZERO_EN
  localparam logic DZ_EXP = 1'b1;
`else
  localparam logic DZ_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  scr1_div_trace_buf #(.DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .mprf_rs1_addr(mprf_rs1_addr),
    .mprf_rs2_addr(mprf_rs2_addr),
    .mprf_rs1_data(mprf_rs1_data),
    .mprf_rs2_data(mprf_rs2_data),
    .trc_vld      (trc_vld),
    .trc_rdy      (trc_rdy),
    .trc_op       (trc_op),
    .trc_dividend (trc_dividend),
    .trc_divisor  (trc_divisor),
    .trc_dz       (trc_dz),
    .evt_cnt      (evt_cnt),
    .drop_cnt     (drop_cnt),
    .ovf          (ovf),
    .dz_seen      (dz_seen)
  );

  function automatic logic [31:0] rtype(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b);
    imem_rdata    = rtype(7'b0000001, f3, 5'd3, 5'd1, 5'd2);
    mprf_rs1_data = a;
    mprf_rs2_data = b;
    imem_resp     = 2'b01;
  endtask

  task automatic head(input string tag, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_vld"}, 64'(trc_vld), 64'd1);
    chk({tag, "_op"}, 64'(trc_op), 64'(op));
    chk({tag, "_dvd"}, 64'(trc_dividend), 64'(a));
    chk({tag, "_dvs"}, 64'(trc_divisor), 64'(b));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; trc_rdy = 1'b0;
    imem_resp = 2'b00; imem_rdata = 32'h0;
    mprf_rs1_data = 32'h0; mprf_rs2_data = 32'h0;
    step; step;
    rst = 1'b0;
    step;
    chk("rst_vld", 64'(trc_vld), 64'd0);
    chk("rst_evt", 64'(evt_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_dzs", 64'(dz_seen), 64'd0);
    chk("rst_dz", 64'(trc_dz), 64'd0);

    // non-events: wrong resp codes, then MUL
    ev(3'b100, 32'd100, 32'd7);
    chk("rs1_addr", 64'(mprf_rs1_addr), 64'd1);
    chk("rs2_addr", 64'(mprf_rs2_addr), 64'd2);
    imem_resp = 2'b00; step;
    imem_resp = 2'b10; step;
    imem_rdata = rtype(7'b0000001, 3'b000, 5'd3, 5'd1, 5'd2);
    imem_resp = 2'b01; step;
    imem_rdata = rtype(7'b0000000, 3'b100, 5'd3, 5'd1, 5'd2);
    step;
    imem_resp = 2'b00;
    chk("nodet_vld", 64'(trc_vld), 64'd0);
    chk("nodet_evt", 64'(evt_cnt), 64'd0);

    // single DIV, visible next cycle
    ev(3'b100, 32'd100, 32'd7);
    step;
    imem_resp = 2'b00;
    head("div", 2'b00, 32'd100, 32'd7);
    chk("div_evt", 64'(evt_cnt), 64'd1);
    chk("div_dz", 64'(trc_dz), 64'd0);
    trc_rdy = 1'b1; step; trc_rdy = 1'b0;
    chk("div_pop", 64'(trc_vld), 64'd0);

    // overflow: six REMU into a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      ev(3'b111, 32'd10 + 32'(i), 32'd3 + 32'(i));
      step;
    end
    imem_resp = 2'b00;
    chk("ovf_evt", 64'(evt_cnt), 64'd7);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_flag", 64'(ovf), 64'd1);
    step;
    chk("ovf_hold", 64'(trc_vld), 64'd1);
    trc_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head($sformatf("drain%0d", i), 2'b11,
           32'd10 + 32'(i), 32'd3 + 32'(i));
      step;
    end
    chk("drain_empty", 64'(trc_vld), 64'd0);
    trc_rdy = 1'b0;

    // full FIFO with detect and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      ev(3'b111, 32'd20 + 32'(i), 32'd1);
      step;
    end
    ev(3'b100, 32'd50, 32'd9);
    trc_rdy = 1'b1;
    step;
    imem_resp = 2'b00;
    trc_rdy = 1'b0;
    chk("fp_drop", 64'(drop_cnt), 64'd2);
    chk("fp_evt", 64'(evt_cnt), 64'd12);
    // still full: another detect must drop
    ev(3'b101, 32'd77, 32'd1);
    step;
    imem_resp = 2'b00;
    chk("fp_full", 64'(drop_cnt), 64'd3);
    trc_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      head($sformatf("fp%0d", i), 2'b11, 32'd20 + 32'(i), 32'd1);
      step;
    end
    head("fp_last", 2'b00, 32'd50, 32'd9);
    step;
    chk("fp_empty", 64'(trc_vld), 64'd0);
    trc_rdy = 1'b0;

    // DIVU with rs2 = x0 while the register file returns 5
    imem_rdata    = rtype(7'b0000001, 3'b101, 5'd5, 5'd1, 5'd0);
    mprf_rs1_data = 32'd40;
    mprf_rs2_data = 32'd5;
    imem_resp     = 2'b01;
    step;
    imem_resp = 2'b00;
    head("dz", 2'b01, 32'd40, 32'd0);
    chk("dz_flag", 64'(trc_dz), 64'(DZ_EXP));
    chk("dz_seen", 64'(dz_seen), 64'(DZ_EXP));
    trc_rdy = 1'b1; step; trc_rdy = 1'b0;

    // async reset between two pushes
    ev(3'b110, 32'd1, 32'd1);
    step;
    imem_resp = 2'b00;
    chk("pre_rst", 64'(trc_vld), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_vld", 64'(trc_vld), 64'd0);
    chk("async_evt", 64'(evt_cnt), 64'd0);
    chk("async_dzs", 64'(dz_seen), 64'd0);
    rst = 1'b0;
    step;
    ev(3'b100, 32'd8, 32'd2);
    step;
    imem_resp = 2'b00;
    head("post_rst", 2'b00, 32'd8, 32'd2);
    chk("post_evt", 64'(evt_cnt), 64'd1);

    // clear with a concurrent detect
    ev(3'b100, 32'd9, 32'd0);
    clr = 1'b1;
    step;
    clr = 1'b0;
    imem_resp = 2'b00;
    chk("clr_vld", 64'(trc_vld), 64'd0);
    chk("clr_evt", 64'(evt_cnt), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_dzs", 64'(dz_seen), 64'd0);
    chk("clr_dz", 64'(trc_dz), 64'd0);
    step;
    chk("clr_none", 64'(trc_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
